phy_rx_word_deserializer: RTL and testbench

Receive-side lane deserializer that sits directly downstream of the PHY transmit serializer and consumes one serial lane at the bit clock. Searches the incoming bit stream for the 0xBC idle/comma symbol, locks byte alignment after a run of consecutive aligned commas, then regroups non-comma bytes four at a time into 32-bit words with a one-cycle valid pulse. Feeds the RX lane demux / word FIFO.

---
 rtl/phy_rx_word_deserializer.sv | 198 +++++++++++++++++++
 tb/tb_phy_rx_word_deserializer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_rx_word_deserializer.sv
// ---------------------------------------------------------------------------
// phy_rx_word_deserializer
//
// Receive-side lane deserializer. Consumes one serial lane at the bit clock,
// slides an 8-bit window over the stream looking for the idle/comma symbol,
// locks byte alignment after BC_LOCK_COUNT consecutive aligned commas, then
// regroups non-comma bytes four at a time into 32-bit words. Each completed
// word is presented on data_out together with a one-cycle valid_out pulse.
//
// Parameters:
//   BC_LOCK_COUNT  consecutive aligned commas needed for lock (1..15)
//   COMMA          idle/comma symbol value
//
// Ports:
//   clk_32f     in   1   bit clock, all logic on the rising edge
//   reset       in   1   synchronous, active-high reset
//   data_in     in   1   serial lane, MSB of each byte first
//   data_out    out  32  last assembled word, first received byte in [31:24]
//   valid_out   out  1   one-cycle pulse when data_out updates
//   active_out  out  1   high while byte alignment is locked
//   err_cnt     out  8   saturating count of discarded partial words
//                        (present only when PHY_RX_ERR_CNT_EN is defined)
//
// Build option:
//   PHY_RX_ERR_CNT_EN  adds the err_cnt port and its counter. Without it,
//                      partial words are still discarded silently.
// ---------------------------------------------------------------------------
module phy_rx_word_deserializer #(
  parameter int         BC_LOCK_COUNT = 4,
  parameter logic [7:0] COMMA         = 8'hBC
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        data_in,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        active_out
`ifdef PHY_RX_ERR_CNT_EN
  ,
  output logic [7:0]  err_cnt
`endif
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    SYNC   = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_CNT = 4'(BC_LOCK_COUNT);

  state_t      state;
  state_t      state_next;
  logic [7:0]  sr;
  logic [7:0]  sr_next;
  logic [2:0]  bit_cnt;
  logic [2:0]  bit_cnt_next;
  logic [3:0]  bc_cnt;
  logic [3:0]  bc_cnt_next;
  logic [3:0]  bc_inc;
  logic [1:0]  byte_idx;
  logic [1:0]  byte_idx_next;
  logic [23:0] word_buf;
  logic [23:0] word_buf_next;
  logic [31:0] data_out_next;
  logic        valid_next;
  logic        active_next;
  logic        is_comma;
  logic        at_boundary;

  // All byte decisions look at the window including the bit arriving this
  // cycle, so a byte is judged in the same cycle its last bit is present.
  assign sr_next     = {sr[6:0], data_in};
  assign is_comma    = (sr_next == COMMA);
  // bit_cnt is cleared on the matching cycle, so it reads 7 exactly eight
  // bits later, which is the next byte boundary.
  assign at_boundary = (bit_cnt == 3'd7);
  assign bc_inc      = bc_cnt + 4'd1;

  always_comb begin
    state_next    = state;
    bit_cnt_next  = bit_cnt;
    bc_cnt_next   = bc_cnt;
    byte_idx_next = byte_idx;
    word_buf_next = word_buf;
    data_out_next = data_out;
    valid_next    = 1'b0;

    unique case (state)
      SEARCH: begin
        // Sliding search: any bit position may start a byte.
        if (is_comma) begin
          bit_cnt_next = 3'd0;
          bc_cnt_next  = 4'd1;
          if (LOCK_CNT == 4'd1) begin
            state_next = SYNC;
          end else begin
            state_next = ALIGN;
          end
        end
      end

      ALIGN: begin
        bit_cnt_next = bit_cnt + 3'd1;
        if (at_boundary) begin
          if (is_comma) begin
            bc_cnt_next = bc_inc;
            if (bc_inc == LOCK_CNT) begin
              state_next = SYNC;
            end
          end else begin
            // Broken run: restart the sliding search on the next bit.
            bc_cnt_next  = 4'd0;
            bit_cnt_next = 3'd0;
            state_next   = SEARCH;
          end
        end
      end

      SYNC: begin
        // Lock is only ever lost through reset.
        bit_cnt_next = bit_cnt + 3'd1;
        if (at_boundary) begin
          if (is_comma) begin
            // Idle symbol: any partially assembled word is dropped.
            byte_idx_next = 2'd0;
          end else begin
            unique case (byte_idx)
              2'd0: word_buf_next[23:16] = sr_next;
              2'd1: word_buf_next[15:8]  = sr_next;
              2'd2: word_buf_next[7:0]   = sr_next;
              2'd3: begin
                data_out_next = {word_buf, sr_next};
                valid_next    = 1'b1;
              end
              default: word_buf_next = word_buf;
            endcase
            // Two-bit index wraps to slot 0 after the fourth byte.
            byte_idx_next = byte_idx + 2'd1;
          end
        end
      end

      default: begin
        state_next = SEARCH;
      end
    endcase

    active_next = (state_next == SYNC);
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state    <= SEARCH;
      sr       <= 8'd0;
      bit_cnt  <= 3'd0;
      bc_cnt   <= 4'd0;
      byte_idx <= 2'd0;
    end else begin
      state    <= state_next;
      sr       <= sr_next;
      bit_cnt  <= bit_cnt_next;
      bc_cnt   <= bc_cnt_next;
      byte_idx <= byte_idx_next;
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      word_buf   <= 24'd0;
      data_out   <= 32'd0;
      valid_out  <= 1'b0;
      active_out <= 1'b0;
    end else begin
      word_buf   <= word_buf_next;
      data_out   <= data_out_next;
      valid_out  <= valid_next;
      active_out <= active_next;
    end
  end

`ifdef PHY_RX_ERR_CNT_EN
  logic partial_drop;

  // A comma seen in the middle of a word means the partial word is lost.
  assign partial_drop = (state == SYNC) && at_boundary && is_comma &&
                        (byte_idx != 2'd0);

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      err_cnt <= 8'd0;
    end else if (partial_drop && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_phy_rx_word_deserializer.sv
// ---------------------------------------------------------------------------
// tb_phy_rx_word_deserializer
//
// Self-checking bench for phy_rx_word_deserializer. Covers reset behaviour,
// lock and word latency, failed alignment, partial-word discard, back-to-back
// words with a reset in the middle of a word, a table of short scenarios, and
// random streams compared cycle by cycle against a bit-array reference model.
// Define PHY_RX_ERR_CNT_EN to also connect and check err_cnt.
// ---------------------------------------------------------------------------
module tb_phy_rx_word_deserializer;

  localparam int         LOCK  = 4;
  localparam logic [7:0] COMMA = 8'hBC;

  logic        clk_32f = 1'b0;
  logic        reset;
  logic        data_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        active_out;
`ifdef PHY_RX_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  always #5 clk_32f = ~clk_32f;

  phy_rx_word_deserializer #(
    .BC_LOCK_COUNT(LOCK),
    .COMMA        (COMMA)
  ) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active_out(active_out)
`ifdef PHY_RX_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int pulse_cnt = 0;
  int          pulse_cyc_q[$];
  logic [31:0] pulse_val_q[$];

  // Reference model storage
  bit          stim_q[$];
  bit          exp_act_q[$];
  bit          exp_val_q[$];
  logic [31:0] exp_dat_q[$];
  int          exp_err_q[$];

  typedef struct {
    int          g_len;
    logic [7:0]  g_bits;
    int          n_bytes;
    logic [95:0] bytes;
    int          exp_pulses;
    logic [31:0] exp_data;
    logic        exp_active;
    int          exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual,
               expected, cyc);
    end
  endtask

  // Drive one bit for one clock, then sample just after the edge.
  task automatic applyStimulus(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
    cyc++;
    if (valid_out === 1'b1) begin
      pulse_cnt++;
      pulse_cyc_q.push_back(cyc);
      pulse_val_q.push_back(data_out);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) applyStimulus(b[k]);
  endtask

  task automatic doReset(input int n);
    reset = 1'b1;
    for (int k = 0; k < n; k++) applyStimulus(1'b0);
    reset = 1'b0;
    pulse_cnt = 0;
    pulse_cyc_q.delete();
    pulse_val_q.delete();
  endtask

  // Byte window ending at bit i (oldest bit is the MSB); bits before the
  // start of the stream read as zero, like a freshly reset shift register.
  function automatic logic [7:0] win(input int i);
    logic [7:0] w;
    int idx;
    for (int k = 0; k < 8; k++) begin
      idx = i - 7 + k;
      w[7 - k] = (idx >= 0) ? stim_q[idx] : 1'b0;
    end
    return w;
  endfunction

  // Expected outputs after each bit of stim_q, derived from the stream:
  // find the lock point first, then walk the byte boundaries after it.
  task automatic computeModel();
    int n, lock, i, j, cnt, idx, errs;
    logic [7:0]  b;
    logic [7:0]  slots[4];
    logic [31:0] dat;
    bit          val;
    n    = stim_q.size();
    lock = -1;
    i    = 0;
    while (i < n && lock < 0) begin
      if (win(i) == COMMA) begin
        cnt = 1;
        j   = i;
        while (cnt < LOCK && j + 8 < n && win(j + 8) == COMMA) begin
          j += 8;
          cnt++;
        end
        if (cnt == LOCK) lock = j;
        else if (j + 8 >= n) i = n;
        else i = j + 9;
      end else begin
        i++;
      end
    end
    exp_act_q.delete();
    exp_val_q.delete();
    exp_dat_q.delete();
    exp_err_q.delete();
    idx  = 0;
    dat  = 32'd0;
    errs = 0;
    for (int c = 0; c < n; c++) begin
      val = 1'b0;
      if (lock >= 0 && c > lock && ((c - lock) % 8) == 0) begin
        b = win(c);
        if (b == COMMA) begin
          if (idx != 0 && errs < 255) errs++;
          idx = 0;
        end else begin
          slots[idx] = b;
          idx++;
          if (idx == 4) begin
            dat = {slots[0], slots[1], slots[2], slots[3]};
            val = 1'b1;
            idx = 0;
          end
        end
      end
      exp_act_q.push_back(lock >= 0 && c >= lock);
      exp_val_q.push_back(val);
      exp_dat_q.push_back(dat);
      exp_err_q.push_back(errs);
    end
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] words[3];
    logic [7:0]  c8;
    logic        seen;
    int          c0, nc;

    reset   = 1'b1;
    data_in = 1'b0;

    vecs[0] = '{3, 8'b101, 4,  96'hBCBCBCBC_00000000_00000000, 0, 32'h0,        1'b1, 0};
    vecs[1] = '{0, 8'h00,  8,  96'hBCBCBCBC_12345678_00000000, 1, 32'h12345678, 1'b1, 0};
    vecs[2] = '{0, 8'h00,  11, 96'hBCBC00BC_BCBCBC12_34567800, 1, 32'h12345678, 1'b1, 0};
    vecs[3] = '{0, 8'h00,  6,  96'hBCBC00BC_BCBC0000_00000000, 0, 32'h0,        1'b0, 0};
    vecs[4] = '{0, 8'h00,  11, 96'hBCBCBCBC_AABBBC01_02030400, 1, 32'h01020304, 1'b1, 1};
    vecs[5] = '{0, 8'h00,  8,  96'hBCBCBCBC_112233BC_00000000, 0, 32'h0,        1'b1, 1};
    vecs[6] = '{0, 8'h00,  12, 96'hBCBCBCBC_A1A2A3A4_B1B2B3B4, 2, 32'hB1B2B3B4, 1'b1, 0};

    // Reset held for three cycles with toggling data, then one cycle after.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(k[0]);
      checkOutput("reset_data", data_out, 32'h0);
      checkOutput("reset_valid", {31'd0, valid_out}, 32'h0);
      checkOutput("reset_active", {31'd0, active_out}, 32'h0);
    end
    reset = 1'b0;
    applyStimulus(1'b1);
    checkOutput("post_reset_data", data_out, 32'h0);
    checkOutput("post_reset_valid", {31'd0, valid_out}, 32'h0);
    checkOutput("post_reset_active", {31'd0, active_out}, 32'h0);

    // Lock timing: garbage 101, then four commas.
    doReset(2);
    seen = 1'b0;
    applyStimulus(1'b1);
    seen |= active_out;
    applyStimulus(1'b0);
    seen |= active_out;
    applyStimulus(1'b1);
    seen |= active_out;
    c8 = COMMA;
    for (int k = 0; k < 32; k++) begin
      applyStimulus(c8[7 - (k % 8)]);
      if (k < 31) seen |= active_out;
    end
    checkOutput("lock_active_early", {31'd0, seen}, 32'h0);
    checkOutput("lock_active_rise", {31'd0, active_out}, 32'h1);
    checkOutput("lock_no_valid", pulse_cnt, 32'd0);

    // First word straight after lock.
    w    = 32'h12345678;
    seen = 1'b0;
    for (int k = 31; k >= 0; k--) begin
      applyStimulus(w[k]);
      if (k > 0) seen |= valid_out;
    end
    checkOutput("word_valid_early", {31'd0, seen}, 32'h0);
    checkOutput("word_valid", {31'd0, valid_out}, 32'h1);
    checkOutput("word_data", data_out, 32'h12345678);

    // Back-to-back words, no idles.
    words[0] = 32'hDEADBEEF;
    words[1] = 32'h00000001;
    words[2] = 32'hFFFFFF00;
    pulse_cnt = 0;
    pulse_cyc_q.delete();
    pulse_val_q.delete();
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin
      w = words[i];
      for (int k = 31; k >= 0; k--) applyStimulus(w[k]);
    end
    checkOutput("b2b_pulses", pulse_cnt, 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < pulse_val_q.size()) begin
        checkOutput($sformatf("b2b_data%0d", i), pulse_val_q[i], words[i]);
        checkOutput($sformatf("b2b_cycle%0d", i), pulse_cyc_q[i], c0 + 32 * (i + 1));
      end
    end

    // Reset in the middle of a fourth word.
    w = 32'hCAFEF00D;
    for (int k = 31; k >= 16; k--) applyStimulus(w[k]);
    reset = 1'b1;
    for (int k = 15; k >= 14; k--) begin
      applyStimulus(w[k]);
      checkOutput("midreset_valid", {31'd0, valid_out}, 32'h0);
      checkOutput("midreset_active", {31'd0, active_out}, 32'h0);
      checkOutput("midreset_data", data_out, 32'h0);
    end
    reset = 1'b0;
    for (int k = 13; k >= 0; k--) applyStimulus(w[k]);
    checkOutput("midreset_no_pulse", pulse_cnt, 32'd3);
    checkOutput("midreset_active_after", {31'd0, active_out}, 32'h0);

    // Table-driven scenarios.
    for (int v = 0; v < 7; v++) begin
      doReset(2);
      for (int k = vecs[v].g_len - 1; k >= 0; k--) applyStimulus(vecs[v].g_bits[k]);
      for (int k = 0; k < vecs[v].n_bytes; k++) sendByte(vecs[v].bytes[95 - 8 * k -: 8]);
      checkOutput($sformatf("vec%0d_pulses", v), pulse_cnt, vecs[v].exp_pulses);
      checkOutput($sformatf("vec%0d_data", v), data_out, vecs[v].exp_data);
      checkOutput($sformatf("vec%0d_active", v), {31'd0, active_out},
                  {31'd0, vecs[v].exp_active});
`ifdef PHY_RX_ERR_CNT_EN
      checkOutput($sformatf("vec%0d_err", v), {24'd0, err_cnt}, vecs[v].exp_err);
`endif
    end

    // Random streams against the reference model.
    for (int r = 0; r < 8; r++) begin
      stim_q.delete();
      nc = $urandom_range(0, 12);
      for (int k = 0; k < nc; k++) stim_q.push_back(1'($urandom_range(0, 1)));
      nc = ($urandom_range(0, 4) == 0) ? $urandom_range(1, LOCK - 1) : LOCK;
      for (int m = 0; m < nc; m++)
        for (int k = 7; k >= 0; k--) stim_q.push_back(COMMA[k]);
      if ($urandom_range(0, 2) == 0) begin
        c8 = 8'($urandom_range(0, 255));
        for (int k = 7; k >= 0; k--) stim_q.push_back(c8[k]);
        for (int m = 0; m < LOCK; m++)
          for (int k = 7; k >= 0; k--) stim_q.push_back(COMMA[k]);
      end
      for (int m = 0; m < 40; m++) begin
        c8 = ($urandom_range(0, 9) == 0) ? COMMA : 8'($urandom_range(0, 255));
        for (int k = 7; k >= 0; k--) stim_q.push_back(c8[k]);
      end
      computeModel();
      doReset(2);
      for (int c = 0; c < stim_q.size(); c++) begin
        applyStimulus(stim_q[c]);
        checkOutput("rand_active", {31'd0, active_out}, {31'd0, exp_act_q[c]});
        checkOutput("rand_valid", {31'd0, valid_out}, {31'd0, exp_val_q[c]});
        checkOutput("rand_data", data_out, exp_dat_q[c]);
`ifdef PHY_RX_ERR_CNT_EN
        checkOutput("rand_err", {24'd0, err_cnt}, exp_err_q[c]);
`endif
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
